// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
package edge_det_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    // Arm counter must hold 0..sync_stages; never narrower than one bit.
    function automatic int arm_cnt_w(input int sync_stages);
        int w;
        w = $clog2(sync_stages + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: optional synchroniser, edge select, pulse flop, sticky pending
// flag and saturating event counter with overflow.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic [1:0]       edge_sel,
    input  logic             armed,
    input  logic             ack,
    input  logic             cnt_clr,
    output logic             pulse,
    output logic             pending,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_s;
    logic             w_raw_rise;
    logic             w_raw_fall;
    logic             w_raw_edge;
    logic             w_edge;
    logic             r_prev;
    logic             r_pulse;
    logic             r_pending;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_sync <= '0;
                else      r_sync <= SYNC_STAGES'({r_sync, sig_in});
            end
            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_raw_rise = w_s & ~r_prev;
    assign w_raw_fall = ~w_s & r_prev;

    always_comb begin
        w_raw_edge = 1'b0;
        case (edge_sel)
            EDGE_RISE: w_raw_edge = w_raw_rise;
            EDGE_FALL: w_raw_edge = w_raw_fall;
            EDGE_BOTH: w_raw_edge = w_raw_rise | w_raw_fall;
            default:   w_raw_edge = 1'b0;
        endcase
    end

    assign w_edge = w_raw_edge & armed;

    // prev follows s unconditionally so mode switches and arming never fake an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= 1'b0;
            r_pulse    <= 1'b0;
            r_pending  <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_prev    <= w_s;
            r_pulse   <= w_edge;
            r_pending <= w_edge | (r_pending & ~ack);
            if (cnt_clr) begin
                r_count    <= w_edge ? CNT_ONE : '0;
                r_overflow <= 1'b0;
            end else if (w_edge) begin
                if (r_count == CNT_MAX) r_overflow <= 1'b1;
                else                    r_count    <= r_count + CNT_ONE;
            end
        end
    end

    assign pulse    = r_pulse;
    assign pending  = r_pending;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/multi_edge_detector.sv
// CHANNELS independent edge detectors sharing one edge mode and one arm
// counter that holds detection off until the synchronisers have filled.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic [1:0]                edge_sel,
    input  logic [CHANNELS-1:0]       ack,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       overflow,
    output logic                      armed
);

    localparam int               ARM_W    = arm_cnt_w(SYNC_STAGES);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

    logic [ARM_W-1:0] r_arm_cnt;
    logic             r_armed;

    // armed rises on the (SYNC_STAGES+1)th clock after release, then sticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            if (r_arm_cnt == ARM_LAST) r_armed   <= 1'b1;
            else                       r_arm_cnt <= r_arm_cnt + ARM_ONE;
        end
    end

    assign armed = r_armed;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            edge_det_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .sig_in   (sig_in[i]),
                .edge_sel (edge_sel),
                .armed    (r_armed),
                .ack      (ack[i]),
                .cnt_clr  (cnt_clr),
                .pulse    (pulse[i]),
                .pending  (pending[i]),
                .count    (count[i*CNT_W +: CNT_W]),
                .overflow (overflow[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench: stimulus queues hand-computed pulse vectors per cycle,
// a negedge monitor compares every cycle; status outputs checked directly.
module tb_multi_edge_detector;
    import edge_det_pkg::*;

    localparam int SYNC = 2;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  sig_in;
    logic [1:0]  edge_sel;
    logic [3:0]  ack;
    logic        cnt_clr;
    logic [3:0]  pulse,   pulse_s;
    logic [3:0]  pending, pending_s;
    logic [31:0] count;
    logic [7:0]  count_s;
    logic [3:0]  overflow, overflow_s;
    logic        armed, armed_s;

    exp_t        exp_q[$];
    exp_t        mon_t;
    logic [3:0]  mon_e;
    int          cyc   = 0;
    int          n_chk = 0;
    int          n_err = 0;

    multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(SYNC), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .edge_sel(edge_sel), .ack(ack),
        .cnt_clr(cnt_clr), .pulse(pulse), .pending(pending), .count(count),
        .overflow(overflow), .armed(armed)
    );

    multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(SYNC), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .sig_in(sig_in), .edge_sel(edge_sel), .ack(ack),
        .cnt_clr(cnt_clr), .pulse(pulse_s), .pending(pending_s), .count(count_s),
        .overflow(overflow_s), .armed(armed_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Every cycle: pulse must equal the queued vector for this cycle, else zero.
    always @(negedge clk) begin
        mon_e = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_t = exp_q.pop_front();
            mon_e = mon_t.val;
        end
        chk("pulse", {28'h0, pulse}, {28'h0, mon_e});
        chk("pulse_s", {28'h0, pulse_s}, {28'h0, mon_e});
    end

    task automatic step(input logic [3:0] s, input logic [3:0] e);
        exp_t t;
        @(negedge clk);
        sig_in = s;
        if (e != 4'h0) begin
            t.cyc = cyc + 1 + SYNC;
            t.val = e;
            exp_q.push_back(t);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_and_arm(input string tag);
        @(negedge clk);
        rst = 1'b1;
        idle(1); chk({tag, "_arm1"}, {31'h0, armed}, 32'h0);
        idle(1); chk({tag, "_arm2"}, {31'h0, armed}, 32'h0);
        idle(1); chk({tag, "_arm3"}, {31'h0, armed}, 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        sig_in   = 4'b0001;
        edge_sel = EDGE_RISE;
        ack      = 4'h0;
        cnt_clr  = 1'b0;
        idle(3);
        chk("rst_armed",   {31'h0, armed},    32'h0);
        chk("rst_pending", {28'h0, pending},  32'h0);
        chk("rst_count",   count,             32'h0);
        chk("rst_ovf",     {28'h0, overflow}, 32'h0);

        // Input 0 held high through reset must not produce a pulse.
        release_and_arm("init");
        idle(3);
        chk("hold_count",   count,            32'h0);
        chk("hold_pending", {28'h0, pending}, 32'h0);

        // Rising mode: rise on ch1 pulses, fall does not.
        step(4'b0011, 4'b0010);
        idle(4);
        chk("rise_pending", {28'h0, pending}, 32'h2);
        chk("rise_count1",  {24'h0, count[15:8]}, 32'h1);
        step(4'b0001, 4'b0000);
        idle(4);
        chk("fall_count1",  {24'h0, count[15:8]}, 32'h1);
        @(negedge clk); ack = 4'b0010;
        @(negedge clk); ack = 4'b0000;
        chk("ack1_pending", {28'h0, pending}, 32'h0);

        // Both-edge mode: six back-to-back toggles on ch2.
        @(negedge clk); edge_sel = EDGE_BOTH;
        idle(2);
        for (int i = 0; i < 6; i++)
            step((i % 2 == 0) ? 4'b0101 : 4'b0001, 4'b0100);
        idle(4);
        chk("both_count2", {24'h0, count[23:16]}, 32'h6);
        chk("both_pending", {28'h0, pending}, 32'h4);
        @(negedge clk); edge_sel = EDGE_OFF;
        idle(3);
        step(4'b0101, 4'b0000);
        step(4'b0001, 4'b0000);
        idle(4);
        chk("off_count2", {24'h0, count[23:16]}, 32'h6);

        // Edge coincident with ack: set wins; a later lone ack clears.
        @(negedge clk); edge_sel = EDGE_RISE;
        idle(2);
        step(4'b1001, 4'b1000);
        @(negedge clk);
        @(negedge clk); ack = 4'b1000;
        @(negedge clk); ack = 4'b0000;
        chk("ackedge_pending", {28'h0, pending}, 32'hC);
        @(negedge clk); ack = 4'b1000;
        @(negedge clk); ack = 4'b0000;
        chk("ack3_pending", {28'h0, pending}, 32'h4);
        chk("ack3_count3", {24'h0, count[31:24]}, 32'h1);

        // Saturation on the 2-bit instance: five rises on ch0.
        for (int i = 0; i < 5; i++) begin
            step(4'b1000, 4'b0000);
            step(4'b1001, 4'b0001);
        end
        idle(4);
        chk("sat_count_s", {24'h0, count_s},    32'h77);
        chk("sat_ovf_s",   {28'h0, overflow_s}, 32'h5);
        chk("sat_count0",  {24'h0, count[7:0]}, 32'h5);
        chk("sat_ovf",     {28'h0, overflow},   32'h0);

        // Sixth rise coincides with cnt_clr.
        step(4'b1000, 4'b0000);
        step(4'b1001, 4'b0001);
        @(negedge clk);
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        chk("clr_count_s", {24'h0, count_s},    32'h01);
        chk("clr_ovf_s",   {28'h0, overflow_s}, 32'h0);
        chk("clr_count",   count,               32'h1);
        chk("clr_pending", {28'h0, pending},    32'h5);
        chk("clr_pending_s", {28'h0, pending_s}, 32'h5);
        chk("clr_armed_s", {31'h0, armed_s},    32'h1);

        // Reset mid-stream clears everything at once and re-runs arming.
        idle(2);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_pulse",   {28'h0, pulse},    32'h0);
        chk("mid_pending", {28'h0, pending},  32'h0);
        chk("mid_count",   count,             32'h0);
        chk("mid_ovf",     {28'h0, overflow}, 32'h0);
        chk("mid_armed",   {31'h0, armed},    32'h0);
        idle(2);
        release_and_arm("mid");
        idle(2);
        step(4'b1011, 4'b0010);
        idle(4);
        chk("post_count",   count,            32'h100);
        chk("post_pending", {28'h0, pending}, 32'h2);

        idle(3);
        chk("sb_drain", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised successor to the single-channel rising-edge pulse generator.
- Detects edges on CHANNELS independent asynchronous sensor inputs, for example parking-lot entry/exit barriers and bay sensors.
- Each input passes through an optional synchroniser, then a runtime-selectable edge detector.
- Outputs per channel: a registered one-cycle pulse, a sticky pending flag with ack handshake, and a saturating event counter.
- Sits between the debouncers and the occupancy/control FSM.

Parameters:
- CHANNELS, 4: number of independent input channels (1..16).
- SYNC_STAGES, 2: synchroniser flops per channel (0..3). 0 bypasses the synchroniser for inputs that are already synchronous.
- CNT_W, 8: width of each per-channel event counter (2..16).

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets); deassertion is synchronous to clk.
- sig_in  in  CHANNELS  clean (debounced) level inputs, bit i = channel i.
- edge_sel  in  2  global edge mode: 00 rising, 01 falling, 10 both, 11 disabled.
- ack  in  CHANNELS  per-channel pending clear, level-sampled.
- cnt_clr  in  1  synchronous clear of all counters and overflow flags.
- pulse  out  CHANNELS  one-cycle registered pulse per detected edge.
- pending  out  CHANNELS  sticky "edge seen" flag.
- count  out  CHANNELS*CNT_W  packed counters; channel i occupies [i*CNT_W +: CNT_W].
- overflow  out  CHANNELS  sticky flag: an edge occurred while the counter was at its maximum.
- armed  out  1  high once edge detection is enabled after reset.

Behaviour:
- Reset (rst=0): all sync flops, prev, pulse, pending, count, overflow and armed go to 0. The arm counter is also cleared.
- Pipeline per channel:
  - sync chain of SYNC_STAGES flops produces s;
  - prev <= s every cycle, in all modes and also while unarmed;
  - raw_rise = s & ~prev; raw_fall = ~s & prev.
- Edge select:
  - raw_edge = raw_rise for mode 00, raw_fall for 01, (raw_rise | raw_fall) for 10, and 0 for 11.
  - edge = raw_edge & armed.
- Latency: an input change sampled at clock edge t0 gives pulse=1 for exactly one cycle, starting after edge t0+SYNC_STAGES. With SYNC_STAGES=2 that is 3 edges. pulse is a flop, never combinational from sig_in.
- Arming:
  - After reset release, an arm counter counts SYNC_STAGES+1 clk cycles. armed then goes to 1 and stays there until the next reset.
  - While armed=0, prev tracks s but no pulse, pending or count activity occurs. An input held high through reset therefore does not produce a spurious rising pulse.
- Back-to-back toggles: a toggle every cycle in mode 10 gives pulse high on consecutive cycles, one per edge, with none lost.
- Mode change: takes effect combinationally on the next comparison. Because prev always tracks, switching mode never creates a pulse on its own.
- Pending:
  - Set on edge; cleared on ack=1.
  - Simultaneous edge and ack leaves pending=1 (set wins, so the new event is not lost).
  - ack on an already-clear flag has no effect.
- Counter:
  - count += 1 on edge; saturates at 2^CNT_W-1.
  - An edge at saturation holds count and sets overflow.
  - cnt_clr=1 sets all counts to 0 and clears overflow. If an edge coincides with cnt_clr, that channel's count becomes 1 and its overflow becomes 0.
  - cnt_clr does not affect pending or pulse.
- Channels are fully independent. Simultaneous edges on all channels are all registered in the same cycle.
- Reset mid-operation: everything returns to its reset value immediately, including disarming. The full arm period is repeated after release.

Decomposition:
- Package edge_det_pkg holds:
  - mode constants EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11;
  - a function computing arm-count width from SYNC_STAGES.
- Sub-module edge_det_channel, instantiated CHANNELS times by generate, contains the synchroniser, prev, edge select, pulse flop, pending flag and saturating counter with overflow.
- Top level holds the arm counter, the armed flag and port packing.

Test Plan:
- Defaults; hold sig_in[0]=1 through reset, release rst -> armed rises after 3 cycles; pulse stays 0, count[0]=0.
- Mode 00; raise sig_in[1] at edge t0 -> pulse[1]=1 only during the cycle after t0+2; pending[1]=1; count[1]=1. Falling edge later -> no pulse.
- Mode 10; toggle sig_in[2] on 6 consecutive cycles -> 6 consecutive pulse[2] cycles; count[2]=6. Switch to mode 11 with the input static -> no pulse.
- Edge coincident with ack[3] -> pending[3] stays 1. A later ack[3] alone -> pending[3]=0.
- CNT_W=2; 5 rising edges on channel 0 -> count=3, overflow[0]=1. cnt_clr coincident with a 6th edge -> count=1, overflow=0.
- Assert rst mid-stream while pending and count are nonzero -> all outputs 0 immediately; armed=0 until 3 cycles after release.
